// File: rtl/dram_cache_axi_master_if.sv
// Request/response and AXI channel bundle for the DRAM cache memory-side AXI initiator.
// The master modport is the initiator's view; slave is the memory/control side view.
interface dram_cache_axi_master_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int TAG_S  = 64,
    parameter int ID_W   = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_wdata;

    logic                    resp_valid;
    logic                    resp_ready;
    logic                    resp_write;
    logic [TAG_S-1:0]        resp_tag;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_hit;
    logic                    resp_err;

    logic [ID_W-1:0]         arid;
    logic [ADDR_W-1:0]       araddr;
    logic                    arvalid;
    logic                    arready;

    logic [ID_W-1:0]         rid;
    logic [TAG_S+DATA_W-1:0] rdata;
    logic                    rvalid;
    logic                    rready;

    logic [ID_W-1:0]         awid;
    logic [ADDR_W-1:0]       awaddr;
    logic                    awvalid;
    logic                    awready;

    logic [ID_W-1:0]         wid;
    logic [DATA_W-1:0]       wdata;
    logic                    wvalid;
    logic                    wready;

    logic [ID_W-1:0]         bid;
    logic                    bvalid;
    logic                    bready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  arready, rid, rdata, rvalid, awready, wready, bid, bvalid,
        output req_ready, resp_valid, resp_write, resp_tag, resp_data, resp_hit, resp_err,
        output arid, araddr, arvalid, rready, awid, awaddr, awvalid, wid, wdata, wvalid, bready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        output arready, rid, rdata, rvalid, awready, wready, bid, bvalid,
        input  req_ready, resp_valid, resp_write, resp_tag, resp_data, resp_hit, resp_err,
        input  arid, araddr, arvalid, rready, awid, awaddr, awvalid, wid, wdata, wvalid, bready
    );
endinterface

// File: rtl/dram_cache_axi_master.sv
// Memory-side AXI initiator: one line read (AR->R) or write (AW+W->B) outstanding at a time.
// Define AXI_MST_TIMEOUT_EN to add a watchdog that aborts stuck waits with resp_err.
module dram_cache_axi_master #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 512,
    parameter int TAG_S          = 64,
    parameter int ID_W           = 16,
    parameter int ID             = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                     clk,
    input logic                     rst,
    dram_cache_axi_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

    state_t state, state_nxt;

    logic aw_done, aw_done_nxt;
    logic w_done, w_done_nxt;
    logic accept, capture, timeout, expired;
    logic write_q, hit_q, err_q;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_S-1:0]  tag_q;
    logic [TAG_S-1:0]  rtag;
    logic              hit_calc;

    logic req_rdy, ar_vld, r_rdy, aw_vld, w_vld, b_rdy, resp_vld;

    // Hit: valid bit set and stored tag field matches the upper address bits
    assign rtag     = bus.rdata[TAG_S+DATA_W-1:DATA_W];
    assign hit_calc = rtag[TAG_S-1] && (rtag[TAG_S-3 -: 32] == addr_q[ADDR_W-1 -: 32]);

`ifdef AXI_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             wait_st;

    assign wait_st = (state == AR) || (state == R) || (state == AWW) || (state == B);
    assign expired = wait_st && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (wait_st) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout     = 1'b0;
        req_rdy     = 1'b0;
        ar_vld      = 1'b0;
        r_rdy       = 1'b0;
        aw_vld      = 1'b0;
        w_vld       = 1'b0;
        b_rdy       = 1'b0;
        resp_vld    = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = bus.req_write ? AWW : AR;
                end
            end
            AR: begin
                ar_vld = 1'b1;
                if (bus.arready) state_nxt = R;
            end
            R: begin
                r_rdy = 1'b1;
                if (bus.rvalid) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            AWW: begin
                // Each channel retires independently; B waits for both
                aw_vld = !aw_done;
                w_vld  = !w_done;
                if (bus.awready) aw_done_nxt = 1'b1;
                if (bus.wready)  w_done_nxt  = 1'b1;
                if (aw_done_nxt && w_done_nxt) begin
                    state_nxt   = B;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            B: begin
                b_rdy = 1'b1;
                if (bus.bvalid) state_nxt = RESP;
            end
            RESP: begin
                resp_vld = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (expired && (state_nxt == state)) begin
            state_nxt   = RESP;
            capture     = 1'b0;
            timeout     = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            write_q <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            if (accept) begin
                write_q <= bus.req_write;
                hit_q   <= 1'b0;
                err_q   <= 1'b0;
            end
            if (capture) hit_q <= hit_calc;
            if (timeout) begin
                err_q <= 1'b1;
                hit_q <= 1'b0;
            end
        end
    end

    // Payload registers carry no reset; outputs are gated by state so they read 0 when idle
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= {bus.req_addr[ADDR_W-1:6], 6'b0};
            wdata_q <= bus.req_wdata;
        end
        if (capture) begin
            tag_q  <= rtag;
            data_q <= bus.rdata[DATA_W-1:0];
        end
    end

    assign bus.req_ready  = req_rdy && !rst;

    assign bus.arid       = ID_W'(ID);
    assign bus.arvalid    = ar_vld;
    assign bus.araddr     = ar_vld ? addr_q : '0;
    assign bus.rready     = r_rdy;

    assign bus.awid       = ID_W'(ID);
    assign bus.awvalid    = aw_vld;
    assign bus.awaddr     = aw_vld ? addr_q : '0;
    assign bus.wid        = ID_W'(ID);
    assign bus.wvalid     = w_vld;
    assign bus.wdata      = w_vld ? wdata_q : '0;
    assign bus.bready     = b_rdy;

    assign bus.resp_valid = resp_vld;
    assign bus.resp_write = resp_vld && write_q;
    assign bus.resp_err   = resp_vld && err_q;
    assign bus.resp_hit   = resp_vld && !write_q && !err_q && hit_q;
    assign bus.resp_tag   = (resp_vld && !write_q && !err_q) ? tag_q  : '0;
    assign bus.resp_data  = (resp_vld && !write_q && !err_q) ? data_q : '0;

    logic unused_sig;
    assign unused_sig = ^{bus.rid, bus.bid, (TIMEOUT_CYCLES > 0)};

endmodule

// File: tb/tb_dram_cache_axi_master.sv
// Bench for dram_cache_axi_master: directed requests against a small tag+data slave model,
// with a scoreboard queue checked by an independent response monitor.
module tb_dram_cache_axi_master;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int TAG_S  = 64;
    localparam int ID_W   = 16;
    localparam int ID     = 1;
    localparam int TO     = 16;

    localparam logic [63:0]  ADDR_A = 64'h0000_0001_0000_0040;
    localparam logic [63:0]  ADDR_B = 64'h0000_0002_0000_0040;
    localparam logic [63:0]  ADDR_C = 64'h0000_0003_0000_0080;
    localparam logic [63:0]  TAG_A  = 64'h8000_0000_4000_0000;
    localparam logic [63:0]  TAG_C  = 64'h8000_0000_C000_0000;
    localparam logic [511:0] PA5    = {64{8'hA5}};
    localparam logic [511:0] P5A    = {64{8'h5A}};

    typedef struct {
        logic         wr;
        logic [63:0]  tag;
        logic [511:0] data;
        logic         hit;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dram_cache_axi_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_S(TAG_S), .ID_W(ID_W)) bus();

    dram_cache_axi_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_S(TAG_S), .ID_W(ID_W), .ID(ID), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_check = 0;
    int   n_pass  = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   resp_cnt = 0;
    int   hold_cycles = 0;
    int   ar_stall = 0, r_stall = 0, aw_stall = 0, w_stall = 0;
    exp_t sb[$];
    logic [575:0] mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic push(input logic wr, input logic [63:0] tag, input logic [511:0] data,
                        input logic hit, input logic err, input int lat);
        exp_t e;
        e.wr = wr; e.tag = tag; e.data = data; e.hit = hit; e.err = err; e.lat = lat;
        sb.push_back(e);
    endtask

    function automatic logic [639:0] pack_resp();
        return {bus.resp_write, bus.resp_hit, bus.resp_err, bus.resp_tag, bus.resp_data};
    endfunction

    // Slave: tag word is {valid, 0, addr[63:32], 30'b0}, indexed by addr[15:6]
    initial begin : slave
        int aw_wait, w_wait, ar_wait, r_wait;
        logic aw_got, w_got, rd_pend, aw_hs, w_hs;
        logic [63:0] waddr, raddr;
        logic [511:0] wd;
        aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; rd_pend = 0; waddr = '0; raddr = '0; wd = '0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rid = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
                aw_got = 0; w_got = 0; rd_pend = 0;
                continue;
            end
            if (bus.bvalid) bus.bvalid = 0;
            if (bus.rvalid) bus.rvalid = 0;

            if (bus.arready) begin
                bus.arready = 0; rd_pend = 1; r_wait = 0;
            end else if (bus.arvalid) begin
                if (ar_wait >= ar_stall) begin bus.arready = 1; raddr = bus.araddr; ar_wait = 0; end
                else ar_wait++;
            end else ar_wait = 0;

            aw_hs = bus.awready;
            w_hs  = bus.wready;
            if (aw_hs) begin bus.awready = 0; aw_got = 1; end
            else if (bus.awvalid) begin
                if (aw_wait >= aw_stall) begin bus.awready = 1; waddr = bus.awaddr; aw_wait = 0; end
                else aw_wait++;
            end else aw_wait = 0;
            if (w_hs) begin bus.wready = 0; w_got = 1; end
            else if (bus.wvalid) begin
                if (w_wait >= w_stall) begin bus.wready = 1; wd = bus.wdata; w_wait = 0; end
                else w_wait++;
            end else w_wait = 0;
            if (aw_hs) chk("awvalid_drop", bus.awvalid, 0);
            if (w_hs)  chk("wvalid_drop", bus.wvalid, 0);
            if ((aw_hs || w_hs) && !(aw_got && w_got)) chk("bready_early", bus.bready, 0);
            if (aw_got && w_got) begin
                mem[int'(waddr[15:6])] = {1'b1, 1'b0, waddr[63:32], 30'b0, wd};
                bus.bvalid = 1; aw_got = 0; w_got = 0;
            end

            if (rd_pend && bus.rready) begin
                if (r_wait >= r_stall) begin
                    bus.rdata = mem.exists(int'(raddr[15:6])) ? mem[int'(raddr[15:6])] : '0;
                    bus.rvalid = 1; rd_pend = 0;
                end else r_wait++;
            end
        end
    end

    initial begin : monitor
        logic seen;
        int hold_left, first_cyc;
        logic [639:0] snap;
        exp_t e;
        seen = 0; hold_left = 0; first_cyc = 0; snap = '0;
        bus.resp_ready = 0;
        forever begin
            @(negedge clk);
            if (rst) begin bus.resp_ready = 0; seen = 0; continue; end
            if (bus.resp_ready) begin
                bus.resp_ready = 0;
                chk("req_ready_after_resp", bus.req_ready, 1);
                continue;
            end
            if (bus.resp_valid) begin
                if (!seen) begin
                    seen = 1; hold_left = hold_cycles; snap = pack_resp(); first_cyc = cyc;
                end
                if (hold_left > 0) begin
                    chk("resp_stable", pack_resp(), snap);
                    chk("req_ready_in_resp", bus.req_ready, 0);
                    hold_left--;
                end else begin
                    if (sb.size() == 0) begin
                        n_check++;
                        $display("FAIL unexpected_resp: actual response present required none");
                    end else begin
                        e = sb.pop_front();
                        chk("resp_write", bus.resp_write, e.wr);
                        chk("resp_tag", bus.resp_tag, e.tag);
                        chk("resp_data", bus.resp_data, e.data);
                        chk("resp_hit", bus.resp_hit, e.hit);
                        chk("resp_err", bus.resp_err, e.err);
                        if (e.lat > 0) chk("resp_latency", first_cyc - accept_cyc, e.lat);
                    end
                    bus.resp_ready = 1; seen = 0; resp_cnt++;
                end
            end
        end
    end

    task automatic send(input logic w, input logic [63:0] a, input logic [511:0] d);
        int n;
        n = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            n_check++;
            $display("FAIL req_ready_wait: actual 0 required 1");
        end
        bus.req_valid = 1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
        accept_cyc = cyc;
        @(negedge clk);
        bus.req_valid = 0;
        chk("req_ready_busy", bus.req_ready, 0);
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_cnt < target && n < 200) begin @(negedge clk); n++; end
        if (resp_cnt < target) begin
            n_check++;
            $display("FAIL resp_wait: actual %0d responses required %0d", resp_cnt, target);
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int n;
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
        #1 rst = 1;
        #1;
        chk("rst_ctrl_outputs", {bus.req_ready, bus.resp_valid, bus.arvalid, bus.rready,
                                 bus.awvalid, bus.wvalid, bus.bready, bus.resp_err}, 0);
        chk("rst_payload", {bus.araddr, bus.awaddr, bus.resp_tag}, 0);
        chk("rst_ids", {bus.arid, bus.awid, bus.wid}, {16'd1, 16'd1, 16'd1});
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("idle_req_ready", bus.req_ready, 1);

        push(1, '0, '0, 0, 0, 3);
        send(1, ADDR_A, PA5);
        wait_resp(1);

        push(0, TAG_A, PA5, 1, 0, 3);
        send(0, ADDR_A, '0);
        wait_resp(2);

        push(0, TAG_A, PA5, 0, 0, 3);
        send(0, ADDR_B, '0);
        wait_resp(3);

        aw_stall = 5;
        push(1, '0, '0, 0, 0, 0);
        send(1, ADDR_C, P5A);
        wait_resp(4);
        aw_stall = 0;

        w_stall = 5;
        push(1, '0, '0, 0, 0, 0);
        send(1, ADDR_C, P5A);
        wait_resp(5);
        w_stall = 0;

        hold_cycles = 10;
        push(0, TAG_C, P5A, 1, 0, 3);
        send(0, ADDR_C, '0);
        wait_resp(6);
        hold_cycles = 0;

        r_stall = 20;
        send(0, ADDR_A, '0);
        n = 0;
        while (!bus.rready && n < 20) begin @(negedge clk); n++; end
        chk("rready_before_rst", bus.rready, 1);
        rst = 1;
        #1;
        chk("rst_mid_rready", bus.rready, 0);
        chk("rst_mid_outputs", {bus.arvalid, bus.awvalid, bus.wvalid, bus.bready,
                                bus.resp_valid, bus.req_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        r_stall = 0;
        repeat (5) @(negedge clk);
        chk("no_resp_after_rst", resp_cnt, 6);
        chk("idle_after_rst", bus.req_ready, 1);

        push(0, TAG_A, PA5, 1, 0, 3);
        send(0, ADDR_A, '0);
        wait_resp(7);

`ifdef AXI_MST_TIMEOUT_EN
        ar_stall = 1000;
        push(0, '0, '0, 0, 1, 17);
        send(0, ADDR_A, '0);
        wait_resp(8);
        ar_stall = 0;
        chk("resp_count", resp_cnt, 8);
`else
        chk("resp_count", resp_cnt, 7);
`endif
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/dram_cache_axi_master.md
# dram_cache_axi_master

AXI initiator on the memory side of the DRAM cache controller. It takes one line-sized request at a time from the cache control logic and converts it to an AXI read (AR→R) or write (AW+W→B) transaction. It is the counterpart of the tag+data slave memory model. For reads, it returns the 64-bit tag word and the 512-bit line, together with a hit indication computed against the request address.

## Interface
Parameters:
- ADDR_W, 64: address width
- DATA_W, 512: line data width
- TAG_S, 64: tag word width; rdata is {tag, data}
- ID_W, 16: AXI ID width
- ID, 1: constant driven on arid/awid/wid
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with the timeout macro

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  **asynchronous, active-high reset**
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with valid
- req_write_i  in  1  1 = write line, 0 = read line
- req_addr_i  in  ADDR_W  line address; bits [5:0] ignored
- req_wdata_i  in  DATA_W  write data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- resp_write_o  out  1  echoes req_write of the completed transaction
- resp_tag_o  out  TAG_S  tag word from the read; 0 for writes
- resp_data_o  out  DATA_W  line data from the read; 0 for writes
- resp_hit_o  out  1  read only: tag[63]==1 and tag[61:30]==addr[63:32]
- resp_err_o  out  1  transaction aborted by the watchdog
- arid_o, araddr_o, arvalid_o / arready_i  AXI AR channel
- rid_i, rdata_i[TAG_S+DATA_W], rvalid_i / rready_o  AXI R channel; rid_i is ignored
- awid_o, awaddr_o, awvalid_o / awready_i  AXI AW channel
- wid_o, wdata_o, wvalid_o / wready_i  AXI W channel
- bid_i, bvalid_i / bready_o  AXI B channel; bid_i is ignored

## Operation
- FSM states: IDLE, AR, R, AWW, B, RESP. Only one transaction is outstanding at a time.
- **IDLE:**
  - req_ready_o=1.
  - On req_valid_i, latch write/addr/wdata. Go to AWW if write, otherwise AR.
- **AR:**
  - arvalid_o=1, araddr_o = latched addr with [5:0] forced to 0.
  - On arready_i go to R.
- **R:**
  - rready_o=1.
  - On rvalid_i, capture rdata_i[575:512] into the tag register and rdata_i[511:0] into the data register.
  - Compute hit from the captured tag and latched addr, then go to RESP.
- **AWW:**
  - awvalid_o and wvalid_o are raised together.
  - Each channel has its own done flag. awvalid_o drops after its own handshake, and wvalid_o drops after its own.
  - When both flags are set (same cycle allowed), go to B.
- **B:**
  - bready_o=1.
  - On bvalid_i go to RESP.
- **RESP:**
  - resp_valid_o=1 with stable payload.
  - On resp_ready_i go to IDLE. New requests are accepted only from the following cycle.
- AXI valids, once raised, are held with constant payload until their handshake.
- Write responses drive tag, data and hit to 0.

## Timing
- Reset (async assert, removal synchronous to clk):
  - All outputs are 0 except arid_o/awid_o/wid_o, which are ID.
  - FSM goes to IDLE; done flags and the watchdog counter are cleared.
- Reset mid-transaction aborts the transaction immediately: valids drop combinationally with rst and no response is produced.
- Read minimum latency: request accepted at cycle N → arvalid_o at N+1 → (arready at N+1) rready_o at N+2 → (rvalid at N+2) resp_valid_o at N+3.
- Write minimum latency: accepted at N → awvalid/wvalid at N+1 → both accepted at N+1 → bready at N+2 → bvalid at N+2 → resp_valid at N+3.
- req_ready_o is 0 in every state except IDLE. There are no back-to-back accepts without an intervening RESP.
- Handshake and state outputs are registered state decodes. No combinational path from AXI inputs to AXI valid/ready outputs.

## Configuration
- **AXI_MST_TIMEOUT_EN defined:**
  - A counter clears on entry to AR, R, AWW or B and increments every cycle spent waiting.
  - On reaching TIMEOUT_CYCLES-1 with no completing handshake, all AXI valids/readies drop, the FSM goes to RESP with resp_err_o=1, and tag/data/hit are 0.
  - This intentionally breaks AXI rules and is a simulation/debug aid.
- **Not defined:** the counter is absent, resp_err_o is tied 0, and waits are unbounded.

## Test plan
- Write addr 0x0000_0001_0000_0040, data 512'hA5 repeated, against the slave model, instant resp_ready → resp_valid with resp_write=1, err=0; resp_valid appears 3 cycles after accept when the slave is ready immediately.
- Read the same addr → resp_tag=0x8000_0000_4000_0000, resp_data = A5 pattern, resp_hit=1.
- Read 0x0000_0002_0000_0040 (same index, different tag) → resp_hit=0, resp_tag=0x8000_0000_4000_0000.
- Stall awready 5 cycles while wready is immediate (and the reverse) → wvalid/awvalid each drop after their own handshake; B is entered only when both are done; exactly one response.
- Hold resp_ready=0 for 10 cycles → resp_valid and payload stable, req_ready=0 throughout; accept resumes the cycle after resp_ready.
- Assert rst while in R with rready high → rready_o and all valids 0 in the same cycle, no response, FSM in IDLE. With AXI_MST_TIMEOUT_EN and TIMEOUT_CYCLES=16 and arready never asserted → resp_err=1 after 16 wait cycles.
